// File: rtl/opll_write_scheduler.sv
// Host-to-OPLL write scheduler: queues {A0,D} writes and replays them as paced CS_n/WR_n strobes.
// First strobe on the first phiM enable after a push; pushes while full are dropped and flagged.
module opll_write_scheduler #(
   parameter int FIFO_AW    = 3,
   parameter int STROBE_LEN = 4,
   parameter int ADDR_WAIT  = 12,
   parameter int DATA_WAIT  = 84
) (
   input  logic               i_EMUCLK,
   input  logic               i_RST_n,
   input  logic               i_phiM_PCEN_n,
   input  logic               i_HOST_WR,
   input  logic               i_HOST_A0,
   input  logic [7:0]         i_HOST_D,
   output logic               o_HOST_FULL,
   output logic               o_HOST_BUSY,
   output logic               o_HOST_OVF,
   input  logic               i_OVF_CLR,
   output logic [FIFO_AW:0]   o_LEVEL,
   output logic               o_CS_n,
   output logic               o_WR_n,
   output logic               o_A0,
   output logic [7:0]         o_D
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam int MAXW  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int SW    = $clog2(STROBE_LEN + 1);
   localparam int WW    = $clog2(MAXW + 1);

   typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_t;

   logic [8:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]      count;
   logic [8:0]         head;

   state_t             state, state_nx;
   logic [SW-1:0]      scnt, scnt_nx;
   logic [WW-1:0]      wcnt, wcnt_nx;
   logic               cs_nx, wr_nx, a0_nx;
   logic [7:0]         d_nx;
   logic               en, full, empty, push, pop;

   assign en    = ~i_phiM_PCEN_n;
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign push  = i_HOST_WR & ~full;
   assign head  = mem[rd_ptr];

   assign o_HOST_FULL = full;
   assign o_HOST_BUSY = ~empty | (state != S_IDLE);
   assign o_LEVEL     = count;

   always_ff @(posedge i_EMUCLK) begin
      if (push)
         mem[wr_ptr] <= {i_HOST_A0, i_HOST_D};
   end

   // FULL is taken from the pre-edge count, so a same-edge pop never admits the push.
   always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_HOST_OVF <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + FIFO_AW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (i_HOST_WR & full)
            o_HOST_OVF <= 1'b1;
         else if (i_OVF_CLR)
            o_HOST_OVF <= 1'b0;
      end
   end

   always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state  <= S_IDLE;
         scnt   <= '0;
         wcnt   <= '0;
         o_CS_n <= 1'b1;
         o_WR_n <= 1'b1;
         o_A0   <= 1'b0;
         o_D    <= 8'h00;
      end else begin
         state  <= state_nx;
         scnt   <= scnt_nx;
         wcnt   <= wcnt_nx;
         o_CS_n <= cs_nx;
         o_WR_n <= wr_nx;
         o_A0   <= a0_nx;
         o_D    <= d_nx;
      end
   end

   always_comb begin
      state_nx = state;
      scnt_nx  = scnt;
      wcnt_nx  = wcnt;
      cs_nx    = o_CS_n;
      wr_nx    = o_WR_n;
      a0_nx    = o_A0;
      d_nx     = o_D;
      pop      = 1'b0;
      if (en) begin
         case (state)
            S_IDLE: begin
               if (!empty)
                  pop = 1'b1;
            end
            S_STROBE: begin
               if (scnt == '0) begin
                  cs_nx    = 1'b1;
                  wr_nx    = 1'b1;
                  wcnt_nx  = o_A0 ? WW'(DATA_WAIT - 1) : WW'(ADDR_WAIT - 1);
                  state_nx = S_WAIT;
               end else begin
                  scnt_nx = scnt - SW'(1);
               end
            end
            S_WAIT: begin
               if (wcnt != '0)
                  wcnt_nx = wcnt - WW'(1);
               else if (!empty)
                  pop = 1'b1;
               else
                  state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
         endcase
      end
      // A pop always starts a strobe; A0/D then hold until the next pop.
      if (pop) begin
         a0_nx    = head[8];
         d_nx     = head[7:0];
         cs_nx    = 1'b0;
         wr_nx    = 1'b0;
         scnt_nx  = SW'(STROBE_LEN - 1);
         state_nx = S_STROBE;
      end
   end

endmodule

// File: tb/tb_opll_write_scheduler.sv
// Bench for opll_write_scheduler: enable-indexed timing model plus directed literal checks.
module tb_opll_write_scheduler;

   localparam int STRB = 4;
   localparam int AW   = 12;
   localparam int DW   = 84;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pcen_n = 1'b1;
   logic       host_wr = 1'b0;
   logic       host_a0 = 1'b0;
   logic [7:0] host_d = 8'h00;
   logic       ovf_clr = 1'b0;
   logic       full, busy, ovf, cs_n, wr_n, a0;
   logic [3:0] level;
   logic [7:0] d;

   always #5 clk = ~clk;

   opll_write_scheduler #(.FIFO_AW(3), .STROBE_LEN(STRB), .ADDR_WAIT(AW), .DATA_WAIT(DW)) dut (
      .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(pcen_n),
      .i_HOST_WR(host_wr), .i_HOST_A0(host_a0), .i_HOST_D(host_d),
      .o_HOST_FULL(full), .o_HOST_BUSY(busy), .o_HOST_OVF(ovf), .i_OVF_CLR(ovf_clr),
      .o_LEVEL(level), .o_CS_n(cs_n), .o_WR_n(wr_n), .o_A0(a0), .o_D(d)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Model: e counts enabled edges; a pop at enable n holds WR_n low until n+STRB
   // and forbids the next pop until n+STRB+wait.
   logic [8:0] mq[$];
   int         e = 0, rise_at = 0, next_ok = 0, pre = 0;
   logic       dopop = 1'b0;
   logic       m_a0 = 1'b0, m_ovf = 1'b0;
   logic [7:0] m_d = 8'h00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         e = 0; rise_at = 0; next_ok = 0;
         m_a0 = 1'b0; m_d = 8'h00; m_ovf = 1'b0;
      end else begin
         pre = mq.size();
         dopop = 1'b0;
         if (!pcen_n) begin
            e++;
            dopop = (pre > 0) && (e >= next_ok);
         end
         if (dopop) begin
            {m_a0, m_d} = mq.pop_front();
            rise_at = e + STRB;
            next_ok = e + STRB + (m_a0 ? DW : AW);
         end
         if (host_wr && pre < 8)
            mq.push_back({host_a0, host_d});
         if (host_wr && pre == 8)
            m_ovf = 1'b1;
         else if (ovf_clr)
            m_ovf = 1'b0;
      end
   end

   int fall_q[$], rise_q[$], fd_q[$];
   int low_clks = 0, busy_fall_e = -1;
   logic prev_wr = 1'b1, prev_busy = 1'b0;

   always @(negedge clk) begin
      chk("cs_n", cs_n, (e < rise_at) ? 0 : 1);
      chk("wr_n", wr_n, (e < rise_at) ? 0 : 1);
      chk("a0", a0, m_a0);
      chk("d", d, m_d);
      chk("level", level, mq.size());
      chk("full", full, (mq.size() == 8) ? 1 : 0);
      chk("busy", busy, (mq.size() != 0 || e < next_ok) ? 1 : 0);
      chk("ovf", ovf, m_ovf);
      if (prev_wr && !wr_n) begin
         fall_q.push_back(e);
         fd_q.push_back(int'(d));
      end
      if (!prev_wr && wr_n)
         rise_q.push_back(e);
      if (!wr_n)
         low_clks++;
      if (prev_busy && !busy)
         busy_fall_e = e;
      prev_wr = wr_n;
      prev_busy = busy;
   end

   int pmode = 0;
   int cyc = 0;

   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
      case (pmode)
         0: pcen_n = 1'b0;
         1: pcen_n = (cyc % 4 == 0) ? 1'b0 : 1'b1;
         2: pcen_n = 1'($urandom_range(0, 1));
         3: pcen_n = 1'b1;
         default: ;
      endcase
   endtask

   task automatic push(input logic pa0, input logic [7:0] pd);
      host_wr = 1'b1; host_a0 = pa0; host_d = pd;
      tick();
      host_wr = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      chk("idle_timeout", busy, 0);
      tick();
   endtask

   task automatic clear_mon();
      fall_q.delete(); rise_q.delete(); fd_q.delete();
      low_clks = 0; busy_fall_e = -1;
   endtask

   initial begin
      // Reset values with phiM every 4th clock
      pmode = 1;
      repeat (6) tick();
      chk("rst_wr_n", wr_n, 1); chk("rst_cs_n", cs_n, 1);
      chk("rst_d", d, 0); chk("rst_a0", a0, 0); chk("rst_level", level, 0);
      chk("rst_busy", busy, 0); chk("rst_ovf", ovf, 0); chk("rst_full", full, 0);
      rst_n = 1'b1;
      tick();
      clear_mon();
      push(1'b0, 8'h30);
      wait_idle(2000);
      chk("t1_strobes", fall_q.size(), 1);
      if (fall_q.size() == 1 && rise_q.size() == 1) begin
         chk("t1_d", fd_q[0], 8'h30);
         chk("t1_low_enables", rise_q[0] - fall_q[0], 4);
         chk("t1_busy_drop", busy_fall_e - rise_q[0], 12);
      end
      chk("t1_low_clks", low_clks, 16);

      // Three writes back to back
      pmode = 0;
      tick();
      clear_mon();
      push(1'b0, 8'h10); push(1'b1, 8'h55); push(1'b0, 8'h20);
      wait_idle(1000);
      chk("t2_strobes", fall_q.size(), 3);
      if (fall_q.size() == 3) begin
         chk("t2_gap0", fall_q[1] - fall_q[0], 16);
         chk("t2_gap1", fall_q[2] - fall_q[1], 88);
         chk("t2_d0", fd_q[0], 8'h10); chk("t2_d1", fd_q[1], 8'h55); chk("t2_d2", fd_q[2], 8'h20);
      end

      // Fill with phiM stopped, overflow on the 9th push
      pmode = 3;
      tick();
      for (int i = 0; i < 9; i++) push(1'(i % 2), 8'hA0 + 8'(i));
      chk("t3_full", full, 1); chk("t3_level", level, 8); chk("t3_ovf", ovf, 1);
      pmode = 0;
      clear_mon();
      wait_idle(3000);
      chk("t3_strobes", fall_q.size(), 8);
      if (fall_q.size() == 8)
         for (int i = 0; i < 8; i++) chk("t3_byte", fd_q[i], 8'hA0 + i);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("t3_ovf_clr", ovf, 0);

      // Push on the same edge as a pop while full
      pmode = 3;
      tick();
      for (int i = 0; i < 8; i++) push(1'b0, 8'hC0 + 8'(i));
      chk("t4_full", full, 1);
      pmode = 4;
      pcen_n = 1'b0;
      push(1'b1, 8'hEE);
      pcen_n = 1'b1;
      chk("t4_level", level, 7); chk("t4_ovf", ovf, 1); chk("t4_wr_n", wr_n, 0);
      pmode = 0;
      wait_idle(3000);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

      // Reset during the second strobe enable
      clear_mon();
      push(1'b1, 8'h01); push(1'b0, 8'h02); push(1'b1, 8'h03);
      for (int n = 0; n < 50 && wr_n; n++) tick();
      chk("t5_strobe_seen", wr_n, 0);
      tick();
      #1 rst_n = 1'b0;
      #1;
      chk("t5_wr_n", wr_n, 1); chk("t5_cs_n", cs_n, 1); chk("t5_level", level, 0);
      chk("t5_busy", busy, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      clear_mon();
      repeat (200) tick();
      chk("t5_no_strobe", fall_q.size(), 0);

      // Random phiM gating and random traffic
      pmode = 2;
      clear_mon();
      for (int i = 0; i < 4000; i++) begin
         host_wr = ($urandom_range(0, 19) == 0);
         host_a0 = 1'($urandom_range(0, 1));
         host_d  = 8'($urandom_range(0, 255));
         ovf_clr = ($urandom_range(0, 63) == 0);
         tick();
      end
      host_wr = 1'b0; ovf_clr = 1'b0;
      wait_idle(20000);
      chk("t6_rise_fall_pairs", rise_q.size(), fall_q.size());
      chk("t6_some_strobes", (fall_q.size() > 10) ? 1 : 0, 1);
      for (int i = 0; i < fall_q.size() && i < rise_q.size(); i++)
         chk("t6_low_enables", rise_q[i] - fall_q[i], 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
